// File: rtl/clk_ctrl_pkg.sv
// Shared command and state encodings for the run/halt/step clock controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HALT   = 2'b00,
    OP_RUN    = 2'b01,
    OP_STEP   = 2'b10,
    OP_SETDIV = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STEPPING = 2'b10
  } run_state_t;

endpackage

// File: rtl/clk_run_ctrl_tick_gen.sv
// Divide counter producing a registered one-cycle clock-enable pulse every div cycles.
module clk_tick_gen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             due_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // Counter never exceeds div-1, so wrap happens only through this compare.
  assign wrap  = (cnt_q == (div_i - CNT_W'(1)));
  assign due_o = enable_i && wrap;

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (!clear_i && enable_i) begin
      if (wrap) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/clk_run_ctrl.sv
// Run/halt/single-step controller gating a divided clock-enable for the core.
module clk_run_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 1,
  parameter int unsigned STEP_W  = 8
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [1:0]       cmdOp,
  input  logic [CNT_W-1:0] cmdArg,
  output logic             outTick,
  output logic             outHalted,
  output logic             outStepDone,
  output logic [CNT_W-1:0] outDiv
);

  localparam logic [CNT_W-1:0] DIV_RST = (DEF_DIV == 0) ? CNT_W'(1) : CNT_W'(DEF_DIV);

  run_state_t        state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic              halted_q;
  logic              done_q, done_d;
  cmd_op_t           op;
  logic              accept;
  logic              tick_due;
  logic              gen_enable;

  assign op = cmd_op_t'(cmdOp);

  always_comb begin
    cmdReady = 1'b0;
    unique case (op)
      OP_HALT:   cmdReady = 1'b1;
      OP_RUN:    cmdReady = (state_q != ST_STEPPING);
      OP_STEP:   cmdReady = (state_q == ST_HALTED);
      OP_SETDIV: cmdReady = (state_q == ST_HALTED);
      default:   cmdReady = 1'b0;
    endcase
  end

  assign accept     = cmdValid && cmdReady;
  assign gen_enable = (state_q != ST_HALTED);

  // An accepted command takes priority over a tick due on the same edge.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    done_d  = 1'b0;
    if (accept) begin
      unique case (op)
        OP_HALT: state_d = ST_HALTED;
        OP_RUN:  state_d = ST_RUNNING;
        OP_STEP: begin
          if (cmdArg[STEP_W-1:0] == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_STEPPING;
            rem_d   = cmdArg[STEP_W-1:0];
          end
        end
        OP_SETDIV: div_d = (cmdArg == '0) ? CNT_W'(1) : cmdArg;
        default: ;
      endcase
    end else if (state_q == ST_STEPPING && tick_due) begin
      rem_d = rem_q - STEP_W'(1);
      if (rem_q == STEP_W'(1)) begin
        state_d = ST_HALTED;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q  <= ST_HALTED;
      rem_q    <= '0;
      div_q    <= DIV_RST;
      halted_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      halted_q <= (state_d == ST_HALTED);
      done_q   <= done_d;
    end
  end

  clk_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick_gen (
    .clk_i    (inClk),
    .rst_i    (inRst),
    .enable_i (gen_enable),
    .clear_i  (accept),
    .div_i    (div_q),
    .tick_o   (outTick),
    .due_o    (tick_due)
  );

  assign outHalted   = halted_q;
  assign outStepDone = done_q;
  assign outDiv      = div_q;

endmodule
